// File: rtl/p1v_clk_pkg.sv
// Shared clock-generation definitions: CLK register layout, PLL FSM states,
// default settle times and a small helper for elaboration checks.
package p1v_clk_pkg;

   // CLK register bit positions
   localparam int unsigned CFG_W          = 7;
   localparam int unsigned CLK_PLLENA     = 6;
   localparam int unsigned CLK_OSCENA     = 5;
   localparam int unsigned CLK_OSCM_HI    = 4;
   localparam int unsigned CLK_OSCM_LO    = 3;
   localparam int unsigned CLK_CLKSEL_HI  = 2;
   localparam int unsigned CLK_CLKSEL_LO  = 0;

   // Default settle times in clock_160 cycles (10 us oscillator, 100 us PLL)
   localparam int unsigned OSC_SETTLE_DEF = 1600;
   localparam int unsigned PLL_SETTLE_DEF = 16000;
   localparam int unsigned SETTLE_W_DEF   = 16;

   // Divider width: five taps, X16 down to X1
   localparam int unsigned DIV_W          = 5;

   typedef enum logic [1:0] {
      PLL_OFF      = 2'd0,
      PLL_SETTLING = 2'd1,
      PLL_LOCKED   = 2'd2
   } pll_state_e;

   // CLK register low bits as seen by the clock generator
   typedef struct packed {
      logic       pllena;
      logic       oscena;
      logic [1:0] oscm;
      logic [2:0] clksel;
   } clk_cfg_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Enable-gated saturating up-counter with a registered done flag.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : count while high; clears count and done when low
//   cnt        : current count, saturates at LIMIT
//   done       : set on the edge where cnt reaches LIMIT, held while en
module settle_timer
   import p1v_clk_pkg::*;
#(
   parameter int unsigned LIMIT = OSC_SETTLE_DEF,
   parameter int unsigned W     = SETTLE_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         done
);

   // done looks at the pre-increment count so it rises with cnt==LIMIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         if (cnt != W'(LIMIT)) begin
            cnt <= cnt + W'(1);
         end
         done <= (cnt >= W'(LIMIT - 1));
      end
   end

endmodule

// File: rtl/pll_gen.sv
// Fake-PLL tap generator: models oscillator start-up and PLL lock time, then
// derives the five tap clocks from clock_160 with a registered divider.
// Ports:
//   clock_160  : 160 MHz board clock (only clock)
//   resn       : async active-low reset
//   cfg        : CLK register LSBs, [6]=PLLENA [5]=OSCENA [4:3]=OSCM [2:0]=CLKSEL
//   pllX16..X1 : clock_160 / 2, 4, 8, 16, 32 while locked, else 0
//   osc_ready  : oscillator settled
//   pll_locked : PLL locked, taps running
//   pll_state  : FSM state for debug (OFF=0, SETTLING=1, LOCKED=2)
module pll_gen
   import p1v_clk_pkg::*;
#(
   parameter int unsigned OSC_SETTLE = OSC_SETTLE_DEF,
   parameter int unsigned PLL_SETTLE = PLL_SETTLE_DEF,
   parameter int unsigned SETTLE_W   = SETTLE_W_DEF
) (
   input  logic       clock_160,
   input  logic       resn,
   input  logic [6:0] cfg,
   output logic       pllX16,
   output logic       pllX8,
   output logic       pllX4,
   output logic       pllX2,
   output logic       pllX1,
   output logic       osc_ready,
   output logic       pll_locked,
   output logic [1:0] pll_state
);

   // Counter must hold both settle limits; the lock compare needs PLL_SETTLE >= 2
   if (SETTLE_W < 32 && max_u(OSC_SETTLE, PLL_SETTLE) >= (32'd1 << SETTLE_W)) begin : g_w_chk
      $error("SETTLE_W too narrow for settle limits");
   end
   if (PLL_SETTLE < 2) begin : g_pll_chk
      $error("PLL_SETTLE must be at least 2");
   end

   clk_cfg_t             cfgx;
   pll_state_e           state;
   logic [DIV_W-1:0]     div;
   logic [SETTLE_W-1:0]  osc_cnt;
   logic [SETTLE_W-1:0]  pll_cnt;
   logic                 pll_done;
   logic                 pll_go;
   logic                 pll_run;
   logic                 lock_hit;
   logic                 unused_bits;

   // Input stage: everything downstream sees only the registered copy
   always_ff @(posedge clock_160 or negedge resn) begin
      if (!resn) begin
         cfgx <= '0;
      end else begin
         cfgx <= clk_cfg_t'(cfg);
      end
   end

   // Oscillator start-up model
   settle_timer #(
      .LIMIT (OSC_SETTLE),
      .W     (SETTLE_W)
   ) u_osc_timer (
      .clk   (clock_160),
      .rst_n (resn),
      .en    (cfgx.oscena),
      .cnt   (osc_cnt),
      .done  (osc_ready)
   );

   // pll_run also drops on an abort edge so pll_cnt restarts from zero;
   // lock_hit fires on the edge where pll_cnt advances to PLL_SETTLE-1
   always_comb begin
      pll_go   = cfgx.pllena & osc_ready;
      pll_run  = (state == PLL_SETTLING) & pll_go;
      lock_hit = pll_run & (pll_cnt == SETTLE_W'(PLL_SETTLE - 2));
   end

   // PLL lock-time model
   settle_timer #(
      .LIMIT (PLL_SETTLE),
      .W     (SETTLE_W)
   ) u_pll_timer (
      .clk   (clock_160),
      .rst_n (resn),
      .en    (pll_run),
      .cnt   (pll_cnt),
      .done  (pll_done)
   );

   // PLL FSM; losing PLLENA or osc_ready wins over a same-edge lock
   always_ff @(posedge clock_160 or negedge resn) begin
      if (!resn) begin
         state      <= PLL_OFF;
         div        <= '0;
         pll_locked <= 1'b0;
      end else if (!pll_go) begin
         state      <= PLL_OFF;
         div        <= '0;
         pll_locked <= 1'b0;
      end else begin
         case (state)
            PLL_OFF: begin
               state      <= PLL_SETTLING;
               div        <= '0;
               pll_locked <= 1'b0;
            end
            PLL_SETTLING: begin
               div <= '0;
               if (lock_hit) begin
                  state      <= PLL_LOCKED;
                  pll_locked <= 1'b1;
               end else begin
                  state      <= PLL_SETTLING;
                  pll_locked <= 1'b0;
               end
            end
            PLL_LOCKED: begin
               state      <= PLL_LOCKED;
               div        <= div + DIV_W'(1);
               pll_locked <= 1'b1;
            end
            default: begin
               state      <= PLL_OFF;
               div        <= '0;
               pll_locked <= 1'b0;
            end
         endcase
      end
   end

   // Taps come straight from divider flops: glitch-free, phase-aligned, and
   // zero outside LOCKED because div is held at zero there
   assign pllX16    = div[0];
   assign pllX8     = div[1];
   assign pllX4     = div[2];
   assign pllX2     = div[3];
   assign pllX1     = div[4];
   assign pll_state = state;

   // OSCM/CLKSEL belong to the downstream selector; counts are observation only
   assign unused_bits = ^{cfgx.oscm, cfgx.clksel, osc_cnt, pll_done};

endmodule

// File: tb/tb_pll_gen.sv
// Scoreboard bench for pll_gen with OSC_SETTLE=4, PLL_SETTLE=8.
// Stimulus pushes per-cycle expectations; monitors pop and compare.
module tb_pll_gen;

   localparam int unsigned OSC = 4;
   localparam int unsigned PLL = 8;

   logic       clock_160 = 1'b0;
   logic       resn;
   logic [6:0] cfg;
   logic       pllX16, pllX8, pllX4, pllX2, pllX1;
   logic       osc_ready, pll_locked;
   logic [1:0] pll_state;

   pll_gen #(
      .OSC_SETTLE (OSC),
      .PLL_SETTLE (PLL),
      .SETTLE_W   (16)
   ) dut (
      .clock_160  (clock_160),
      .resn       (resn),
      .cfg        (cfg),
      .pllX16     (pllX16),
      .pllX8      (pllX8),
      .pllX4      (pllX4),
      .pllX2      (pllX2),
      .pllX1      (pllX1),
      .osc_ready  (osc_ready),
      .pll_locked (pll_locked),
      .pll_state  (pll_state)
   );

   always #5 clock_160 = ~clock_160;

   // Posedge counter: the negedge after posedge k sees cyc == k
   int cyc = 0;
   always @(posedge clock_160) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      string       name;
      logic [8:0]  val;
   } exp_t;

   exp_t sq[$];
   exp_t aq[$];
   exp_t mon_e;
   exp_t amon_e;
   int   checks   = 0;
   int   failures = 0;
   event async_ev;

   // {osc_ready, pll_locked, pll_state[1:0], X1, X2, X4, X8, X16}
   function automatic logic [8:0] obs();
      return {osc_ready, pll_locked, pll_state, pllX1, pllX2, pllX4, pllX8, pllX16};
   endfunction

   function automatic logic [8:0] pk(input logic o, input logic l,
                                     input logic [1:0] s, input logic [4:0] t);
      return {o, l, s, t};
   endfunction

   task automatic expect_at(input int c, input string nm, input logic [8:0] v);
      exp_t e;
      e.cyc  = c;
      e.name = nm;
      e.val  = v;
      sq.push_back(e);
   endtask

   task automatic compare(input string nm, input int c,
                          input logic [8:0] got, input logic [8:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cyc=%0d got osc/lk/st/taps=%b/%b/%0d/%b want %b/%b/%0d/%b",
                  nm, c, got[8], got[7], got[6:5], got[4:0],
                  want[8], want[7], want[6:5], want[4:0]);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clock_160);
         #2;
      end
   endtask

   // Clocked monitor
   always @(negedge clock_160) begin
      while (sq.size() != 0 && sq[0].cyc <= cyc) begin
         mon_e = sq.pop_front();
         if (mon_e.cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s expectation for cyc=%0d not sampled (now %0d)",
                     mon_e.name, mon_e.cyc, cyc);
         end else begin
            compare(mon_e.name, cyc, obs(), mon_e.val);
         end
      end
   end

   // Between-edge monitor for asynchronous effects
   always @(async_ev) begin
      while (aq.size() != 0) begin
         amon_e = aq.pop_front();
         compare(amon_e.name, cyc, obs(), amon_e.val);
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t ae;
      resn = 1'b0;
      cfg  = 7'h7F;

      // Reset hold with everything enabled
      for (int c = 1; c <= 5; c++) expect_at(c, "rst_hold", pk(0, 0, 2'd0, 5'd0));
      wait_cyc(5);
      resn = 1'b1;
      expect_at(9,  "osc_pre",    pk(0, 0, 2'd0, 5'd0));
      expect_at(10, "osc_rise",   pk(1, 0, 2'd0, 5'd0));
      expect_at(11, "settling",   pk(1, 0, 2'd1, 5'd0));
      expect_at(17, "settle_end", pk(1, 0, 2'd1, 5'd0));
      expect_at(18, "lock",       pk(1, 1, 2'd2, 5'd0));
      for (int k = 1; k <= 67; k++)
         expect_at(18 + k, "div_run", pk(1, 1, 2'd2, 5'(k % 32)));

      // Drop PLLENA while locked
      wait_cyc(84);
      cfg = 7'h20;
      expect_at(86, "drop_pllena", pk(1, 0, 2'd0, 5'd0));
      expect_at(90, "pllena_off",  pk(1, 0, 2'd0, 5'd0));

      // Restore PLLENA: full relock
      wait_cyc(90);
      cfg = 7'h60;
      expect_at(91, "relock_wait",   pk(1, 0, 2'd0, 5'd0));
      expect_at(92, "relock_settle", pk(1, 0, 2'd1, 5'd0));
      expect_at(98, "relock_end",    pk(1, 0, 2'd1, 5'd0));
      expect_at(99, "relock",        pk(1, 1, 2'd2, 5'd0));
      for (int k = 1; k <= 3; k++)
         expect_at(99 + k, "relock_div", pk(1, 1, 2'd2, 5'(k)));

      // Everything off
      wait_cyc(102);
      cfg = 7'h00;
      expect_at(103, "last_tap", pk(1, 1, 2'd2, 5'd4));
      expect_at(104, "all_off",  pk(0, 0, 2'd0, 5'd0));

      // Oscillator only
      wait_cyc(106);
      cfg = 7'h20;
      expect_at(110, "osc_only_pre", pk(0, 0, 2'd0, 5'd0));
      for (int c = 111; c <= 211; c++) expect_at(c, "osc_only", pk(1, 0, 2'd0, 5'd0));

      // Abort during SETTLING by clearing OSCENA
      wait_cyc(212);
      cfg = 7'h60;
      expect_at(213, "abort_wait",   pk(1, 0, 2'd0, 5'd0));
      expect_at(214, "abort_settle", pk(1, 0, 2'd1, 5'd0));
      expect_at(218, "abort_cnt4",   pk(1, 0, 2'd1, 5'd0));
      wait_cyc(218);
      cfg = 7'h40;
      expect_at(219, "abort_cnt5",    pk(1, 0, 2'd1, 5'd0));
      expect_at(220, "abort_oscdrop", pk(0, 0, 2'd1, 5'd0));
      expect_at(221, "abort_off",     pk(0, 0, 2'd0, 5'd0));
      expect_at(224, "abort_idle",    pk(0, 0, 2'd0, 5'd0));

      // Re-enable from scratch: 4 + 8 cycles
      wait_cyc(225);
      cfg = 7'h60;
      expect_at(229, "reen_osc_pre", pk(0, 0, 2'd0, 5'd0));
      expect_at(230, "reen_osc",     pk(1, 0, 2'd0, 5'd0));
      expect_at(231, "reen_settle",  pk(1, 0, 2'd1, 5'd0));
      expect_at(237, "reen_end",     pk(1, 0, 2'd1, 5'd0));
      expect_at(238, "reen_lock",    pk(1, 1, 2'd2, 5'd0));
      for (int k = 1; k <= 6; k++)
         expect_at(238 + k, "reen_div", pk(1, 1, 2'd2, 5'(k)));

      // Async reset pulse between edges while locked
      wait_cyc(245);
      resn = 1'b0;
      #1;
      ae.cyc  = cyc;
      ae.name = "arst_immediate";
      ae.val  = pk(0, 0, 2'd0, 5'd0);
      aq.push_back(ae);
      ->async_ev;
      #1;
      resn = 1'b1;
      expect_at(245, "arst_after",   pk(0, 0, 2'd0, 5'd0));
      expect_at(246, "arst_off",     pk(0, 0, 2'd0, 5'd0));
      expect_at(249, "arst_osc_pre", pk(0, 0, 2'd0, 5'd0));
      expect_at(250, "arst_osc",     pk(1, 0, 2'd0, 5'd0));
      expect_at(251, "arst_settle",  pk(1, 0, 2'd1, 5'd0));

      wait_cyc(255);
      while (sq.size() != 0) begin
         ae = sq.pop_front();
         checks++;
         failures++;
         $display("FAIL %s expectation for cyc=%0d never sampled", ae.name, ae.cyc);
      end
      while (aq.size() != 0) begin
         ae = aq.pop_front();
         checks++;
         failures++;
         $display("FAIL %s async expectation never sampled", ae.name);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
